// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map, bit positions and bus FSM encoding for the timer block
package timer_pkg;

  localparam logic [2:0] ADDR_TDR  = 3'h0;
  localparam logic [2:0] ADDR_TCR  = 3'h1;
  localparam logic [2:0] ADDR_TSR  = 3'h2;
  localparam logic [2:0] ADDR_TCNT = 3'h3;
  localparam logic [2:0] ADDR_TIER = 3'h4;

  localparam int TCR_LOAD    = 7;
  localparam int TCR_UD      = 5;
  localparam int TCR_EN      = 4;
  localparam int TCR_CKS_LSB = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } apb_state_e;

endpackage

// File: rtl/timer_apb_regs_if.sv
// rtl/timer_apb_regs_if.sv - APB bus bundle between a master and the timer register block
interface timer_apb_regs_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/timer_sticky_flag.sv
// rtl/timer_sticky_flag.sv - one sticky status bit, write-1-to-clear, set beats clear on the same edge
module timer_sticky_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic flag
);

  logic flag_d;
  logic flag_q;

  always_comb begin
    flag_d = flag_q;
    if (clr) flag_d = 1'b0;
    if (set) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag_d;
  end

  assign flag = flag_q;

endmodule

// File: rtl/timer_apb_regs.sv
// rtl/timer_apb_regs.sv - APB register file driving timer_counter controls with sticky OVF/UDF status and irq
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  timer_apb_regs_if.slave       apb,
  input  logic [DATA_WIDTH-1:0] TCNT_In,
  input  logic                  Set_OVF_pulse,
  input  logic                  Set_UDF_pulse,
  output logic [DATA_WIDTH-1:0] count_start_value,
  output logic                  count_load,
  output logic                  count_enable,
  output logic                  count_up_down,
  output logic [1:0]            clk_sel,
  output logic                  irq
);

  apb_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tdr_q, tdr_d;
  logic [DATA_WIDTH-1:0] tcr_q, tcr_d;
  logic [1:0]            tier_q, tier_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic [2:0]            reg_addr;
  logic                  addr_err;
  logic                  access_err;
  logic                  access_phase;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ovf_clr, udf_clr;
  logic                  ovf_flag, udf_flag;

  assign reg_addr     = apb.PADDR[2:0];
  assign addr_err     = (apb.PADDR[ADDR_WIDTH-1:3] != '0) || (reg_addr > ADDR_TIER);
  assign access_err   = addr_err || (apb.PWRITE && (reg_addr == ADDR_TCNT));
  assign access_phase = apb.PSEL && apb.PENABLE;

  // Writes land at the end of the ready cycle so the master's data is held stable across it.
  assign wr_commit = (state_q == WAIT) && access_phase && apb.PWRITE && !access_err;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
      SETUP: begin
        if (!apb.PSEL)         state_d = IDLE;
        else if (apb.PENABLE)  state_d = WAIT;
      end
      WAIT:    state_d = apb.PSEL ? DONE : IDLE;
      DONE:    state_d = (apb.PSEL && !apb.PENABLE) ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      ADDR_TDR:  rd_data = tdr_q;
      ADDR_TCR:  rd_data = tcr_q;
      ADDR_TSR: begin
        rd_data[TSR_OVF] = ovf_flag;
        rd_data[TSR_UDF] = udf_flag;
      end
      ADDR_TCNT: rd_data = TCNT_In;
      ADDR_TIER: rd_data[1:0] = tier_q;
      default:   rd_data = '0;
    endcase
  end

  always_comb begin
    pready_d  = (state_q == SETUP) && access_phase;
    pslverr_d = pready_d && access_err;
    prdata_d  = '0;
    if (pready_d && !apb.PWRITE && !access_err) prdata_d = rd_data;
  end

  always_comb begin
    tdr_d  = tdr_q;
    tcr_d  = tcr_q;
    tier_d = tier_q;
    if (wr_commit) begin
      case (reg_addr)
        ADDR_TDR:  tdr_d = apb.PWDATA;
        ADDR_TCR: begin
          // Only load, direction, enable and prescaler select are real bits.
          tcr_d                                  = '0;
          tcr_d[TCR_LOAD]                        = apb.PWDATA[TCR_LOAD];
          tcr_d[TCR_UD]                          = apb.PWDATA[TCR_UD];
          tcr_d[TCR_EN]                          = apb.PWDATA[TCR_EN];
          tcr_d[TCR_CKS_LSB+1:TCR_CKS_LSB]       = apb.PWDATA[TCR_CKS_LSB+1:TCR_CKS_LSB];
        end
        ADDR_TIER: tier_d = apb.PWDATA[1:0];
        default:   tier_d = tier_q;
      endcase
    end
  end

  assign ovf_clr = wr_commit && (reg_addr == ADDR_TSR) && apb.PWDATA[TSR_OVF];
  assign udf_clr = wr_commit && (reg_addr == ADDR_TSR) && apb.PWDATA[TSR_UDF];

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q   <= IDLE;
      tdr_q     <= '0;
      tcr_q     <= '0;
      tier_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tdr_q     <= tdr_d;
      tcr_q     <= tcr_d;
      tier_q    <= tier_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  timer_sticky_flag u_ovf_flag (
    .clk   (PCLK),
    .rst_n (PRESET_n),
    .set   (Set_OVF_pulse),
    .clr   (ovf_clr),
    .flag  (ovf_flag)
  );

  timer_sticky_flag u_udf_flag (
    .clk   (PCLK),
    .rst_n (PRESET_n),
    .set   (Set_UDF_pulse),
    .clr   (udf_clr),
    .flag  (udf_flag)
  );

  assign apb.PRDATA        = prdata_q;
  assign apb.PREADY        = pready_q;
  assign apb.PSLVERR       = pslverr_q;
  assign count_start_value = tdr_q;
  assign count_load        = tcr_q[TCR_LOAD];
  assign count_enable      = tcr_q[TCR_EN];
  assign count_up_down     = tcr_q[TCR_UD];
  assign clk_sel           = tcr_q[TCR_CKS_LSB+1:TCR_CKS_LSB];
  assign irq               = |({udf_flag, ovf_flag} & tier_q);

endmodule

// File: tb/tb_timer_apb_regs.sv
// tb/tb_timer_apb_regs.sv - table-driven bench for the timer APB register block
module tb_timer_apb_regs;

  logic       PCLK = 1'b0;
  logic       PRESET_n;
  logic [7:0] TCNT_In;
  logic       Set_OVF_pulse;
  logic       Set_UDF_pulse;
  logic [7:0] count_start_value;
  logic       count_load;
  logic       count_enable;
  logic       count_up_down;
  logic [1:0] clk_sel;
  logic       irq;

  always #5 PCLK = ~PCLK;

  timer_apb_regs_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) apb ();

  timer_apb_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .PCLK              (PCLK),
    .PRESET_n          (PRESET_n),
    .apb               (apb),
    .TCNT_In           (TCNT_In),
    .Set_OVF_pulse     (Set_OVF_pulse),
    .Set_UDF_pulse     (Set_UDF_pulse),
    .count_start_value (count_start_value),
    .count_load        (count_load),
    .count_enable      (count_enable),
    .count_up_down     (count_up_down),
    .clk_sel           (clk_sel),
    .irq               (irq)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives the setup phase immediately, returns in T3 with the bus idle.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic udf_at_commit, output logic [7:0] rdata, output logic err);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = wdata;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    check("pready_t1", apb.PREADY, 1'b0);
    @(negedge PCLK);
    check("pready_t2", apb.PREADY, 1'b1);
    rdata = apb.PRDATA;
    err   = apb.PSLVERR;
    Set_UDF_pulse = udf_at_commit;
    @(negedge PCLK);
    Set_UDF_pulse = 1'b0;
    apb.PSEL      = 1'b0;
    apb.PENABLE   = 1'b0;
    check("pready_t3", apb.PREADY, 1'b0);
    check("pslverr_t3", apb.PSLVERR, 1'b0);
  endtask

  task automatic rd_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] rd;
    logic       er;
    apb_xfer(1'b0, addr, 8'h00, 1'b0, rd, er);
    check({name, "_data"}, rd, exp);
    check({name, "_err"}, er, 1'b0);
  endtask

  task automatic wr_do(input logic [7:0] addr, input logic [7:0] data, input logic udf_at_commit);
    logic [7:0] rd;
    logic       er;
    apb_xfer(1'b1, addr, data, udf_at_commit, rd, er);
    check("wr_err", er, 1'b0);
  endtask

  task automatic pulse(input logic ovf);
    if (ovf) Set_OVF_pulse = 1'b1;
    else     Set_UDF_pulse = 1'b1;
    @(negedge PCLK);
    Set_OVF_pulse = 1'b0;
    Set_UDF_pulse = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] rd;
    logic       er;

    apb.PSEL      = 1'b0;
    apb.PENABLE   = 1'b0;
    apb.PWRITE    = 1'b0;
    apb.PADDR     = 8'h00;
    apb.PWDATA    = 8'h00;
    TCNT_In       = 8'h7E;
    Set_OVF_pulse = 1'b0;
    Set_UDF_pulse = 1'b0;
    PRESET_n      = 1'b0;
    repeat (3) @(negedge PCLK);

    check("rst_pready", apb.PREADY, 1'b0);
    check("rst_pslverr", apb.PSLVERR, 1'b0);
    check("rst_prdata", apb.PRDATA, 8'h00);
    check("rst_start_value", count_start_value, 8'h00);
    check("rst_load", count_load, 1'b0);
    check("rst_enable", count_enable, 1'b0);
    check("rst_up_down", count_up_down, 1'b0);
    check("rst_clk_sel", clk_sel, 2'd0);
    check("rst_irq", irq, 1'b0);

    PRESET_n = 1'b1;
    @(negedge PCLK);

    //               wr    addr   wdata  rdata  err
    vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 8'h5A, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h03, 1'b0});
    vecs.push_back('{1'b1, 8'h03, 8'h55, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h03, 8'h00, 8'h7E, 1'b0});
    vecs.push_back('{1'b0, 8'h06, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h05, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h07, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h10, 8'h00, 8'h00, 1'b1});
    vecs.push_back('{1'b1, 8'h40, 8'h11, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h5A, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 8'h01, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h01, 1'b0});
    vecs.push_back('{1'b0, 8'h02, 8'h00, 8'h00, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    check("ctl_start_value", count_start_value, 8'h5A);
    check("ctl_load", count_load, 1'b1);
    check("ctl_enable", count_enable, 1'b1);
    check("ctl_up_down", count_up_down, 1'b1);
    check("ctl_clk_sel", clk_sel, 2'd3);
    check("ctl_irq_idle", irq, 1'b0);

    pulse(1'b1);
    check("ovf_irq_set", irq, 1'b1);
    rd_check("ovf_tsr", 8'h02, 8'h01);
    wr_do(8'h02, 8'h01, 1'b0);
    check("ovf_irq_clr_t3", irq, 1'b0);
    rd_check("ovf_tsr_clr", 8'h02, 8'h00);

    pulse(1'b0);
    check("udf_irq_masked", irq, 1'b0);
    rd_check("udf_tsr", 8'h02, 8'h02);
    wr_do(8'h02, 8'h02, 1'b1);
    rd_check("udf_set_wins", 8'h02, 8'h02);
    wr_do(8'h02, 8'h02, 1'b0);
    rd_check("udf_tsr_clr", 8'h02, 8'h00);

    pulse(1'b1);
    wr_do(8'h02, 8'h00, 1'b0);
    rd_check("w0_keeps_ovf", 8'h02, 8'h01);
    check("w0_irq", irq, 1'b1);

    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b1;
    apb.PADDR   = 8'h00;
    apb.PWDATA  = 8'h33;
    @(negedge PCLK);
    apb.PSEL = 1'b0;
    @(negedge PCLK);
    check("abort_pready", apb.PREADY, 1'b0);
    @(negedge PCLK);
    rd_check("abort_tdr", 8'h00, 8'h5A);

    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b1;
    apb.PADDR   = 8'h00;
    apb.PWDATA  = 8'hAA;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET_n = 1'b0;
    #1;
    check("rstmid_pready", apb.PREADY, 1'b0);
    @(negedge PCLK);
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    PRESET_n    = 1'b1;
    check("rstmid_start_value", count_start_value, 8'h00);
    check("rstmid_load", count_load, 1'b0);
    check("rstmid_clk_sel", clk_sel, 2'd0);
    check("rstmid_irq", irq, 1'b0);
    @(negedge PCLK);
    rd_check("rstmid_tdr", 8'h00, 8'h00);
    rd_check("rstmid_tsr", 8'h02, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
